// File: rtl/fifo_drain.sv
// Read-side drain for sync_fifo: absorbs the registered-read latency and re-presents words as a framed valid/ready stream.
// Optional FIFO_DRAIN_STATS_EN adds a 16-bit accepted-beat counter on pop_count.
module fifo_drain #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_read_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]           pop_count
`endif
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

  occ_state_e              state, state_next;
  logic                    inflight;
  logic [DATA_WIDTH-1:0]   head_q, tail_q;
  logic [BEAT_W-1:0]       beat_cnt;
  logic                    pop;
  logic                    capture;
  logic [1:0]              occ;
  logic [2:0]              credit_sum;

  // Occupancy register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_next;
  end

  // Next occupancy and read issue; a read is only issued if the word it returns is guaranteed a slot
  always_comb begin
    state_next   = state;
    fifo_read_en = 1'b0;
    occ          = 2'(state);
    m_valid      = (state != EMPTY);
    pop          = m_valid & m_ready;
    capture      = inflight & ~flush;
    credit_sum   = 3'(occ) + 3'(inflight) - 3'(pop);
    fifo_read_en = reset_n & ~fifo_empty & ~flush & (credit_sum < 3'd2);

    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY:   if (capture) state_next = ONE;
        ONE: begin
          if (capture && !pop)      state_next = TWO;
          else if (!capture && pop) state_next = EMPTY;
        end
        TWO:     if (pop && !capture) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // In-flight marker: fifo_dout is valid the cycle after a read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) inflight <= 1'b0;
    else          inflight <= fifo_read_en;
  end

  // Skid storage: head feeds m_data, tail holds the second word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (!flush) begin
      unique case (state)
        EMPTY: if (capture) head_q <= fifo_dout;
        ONE: begin
          if (capture && pop) head_q <= fifo_dout;
          else if (capture)   tail_q <= fifo_dout;
        end
        TWO: begin
          if (pop) begin
            head_q <= tail_q;
            if (capture) tail_q <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  // Burst framing counter, restarted by flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      beat_cnt <= '0;
    else if (flush)    beat_cnt <= '0;
    else if (pop) begin
      if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
      else                       beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end

  assign m_data = head_q;
  assign m_last = m_valid & (beat_cnt == LAST_BEAT);

`ifdef FIFO_DRAIN_STATS_EN
  // Accepted beats; a pop during flush was already taken downstream so it still counts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  pop_count <= '0;
    else if (pop)  pop_count <= pop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: queue-based FIFO and stream model, directed phases with randomized data and ready.
module tb_fifo_drain;

  localparam int unsigned DW = 32;
  localparam int unsigned BL = 4;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_read_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0]   pop_count;
`endif

  fifo_drain #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_read_en (fifo_read_en),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .pop_count    (pop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned fq[$];    // words still inside the attached FIFO
  int unsigned expq[$];  // words read from the FIFO and not yet delivered
  int          beat_m;
  bit          infl_m;
  int unsigned pop_m;
  int          errors;
  int          checks;
  int          cyc;
  int          rd_cnt;
  int          first_rd;
  int          first_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic load(input int n, input bit rnd, input int unsigned base);
    for (int i = 0; i < n; i++) fq.push_back(rnd ? $urandom : base + i);
    fifo_empty = (fq.size() == 0);
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model across the edge
  task automatic step(input bit rdy, input bit fl);
    int  occ_m;
    bit  popm;
    bit  rd;
    m_ready = rdy;
    flush   = fl;
    #1;
    occ_m = expq.size() - int'(infl_m);
    check("m_valid", 32'(m_valid), 32'(occ_m > 0));
    check("m_last", 32'(m_last), 32'((occ_m > 0) && (beat_m == BL - 1)));
    if (occ_m > 0) check("m_data", m_data, expq[0]);
    if (fifo_empty) check("read_when_empty", 32'(fifo_read_en), 32'd0);
    if (fl) check("read_during_flush", 32'(fifo_read_en), 32'd0);
    popm = (occ_m > 0) && rdy;
    rd   = fifo_read_en;
    if (rd) rd_cnt++;
    if (rd && first_rd < 0) first_rd = cyc;
    if (m_valid && first_v < 0) first_v = cyc;
    @(posedge clk);
    #1;
    cyc++;
    if (popm) begin
      void'(expq.pop_front());
      beat_m = (beat_m + 1) % BL;
      pop_m++;
    end
    if (fl) begin
      expq.delete();
      beat_m = 0;
    end
    if (rd && fq.size() > 0) begin
      fifo_dout = fq.pop_front();
      expq.push_back(fifo_dout);
    end
    infl_m     = rd;
    fifo_empty = (fq.size() == 0);
    check("occ_plus_inflight_le_2", 32'(expq.size() <= 2), 32'd1);
`ifdef FIFO_DRAIN_STATS_EN
    check("pop_count", 32'(pop_count), 32'(pop_m & 32'hFFFF));
`endif
  endtask

  // mode 0: ready high, 1: alternating, 2: random
  task automatic drain(input int mode, input int maxc);
    bit idle;
    bit r;
    idle = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (fq.size() == 0 && expq.size() == 0) begin
        idle = 1'b1;
        break;
      end
      r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
      step(r, 1'b0);
    end
    if (fq.size() == 0 && expq.size() == 0) idle = 1'b1;
    check("drain_within_budget", 32'(idle), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_read_en", 32'(fifo_read_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", m_data, 32'd0);
`ifdef FIFO_DRAIN_STATS_EN
    check("rst_pop_count", 32'(pop_count), 32'd0);
`endif
    expq.delete();
    beat_m = 0;
    infl_m = 1'b0;
    pop_m  = 0;
    @(posedge clk);
    #1;
    cyc++;
    check("rst_held_read_en", 32'(fifo_read_en), 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    int pops_before;
    errors = 0; checks = 0; cyc = 0; rd_cnt = 0;
    first_rd = -1; first_v = -1;
    beat_m = 0; infl_m = 1'b0; pop_m = 0;
    reset_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b0; fifo_dout = '0;
    #1;

    // Reset with a non-empty FIFO, then first-word latency
    load(4, 1'b0, 32'hA0);
    do_reset();
    first_rd = -1; first_v = -1;
    drain(0, 20);
    check("latency_read_to_valid", 32'(first_v - first_rd), 32'd2);

    // Streaming with burst framing, no bubbles
    load(8, 1'b0, 32'h10);
    pops_before = int'(pop_m);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    check("stream_beats_in_10", 32'(int'(pop_m) - pops_before), 32'd8);
    drain(0, 10);

    // Back-pressure: only two reads while stalled
    load(6, 1'b1, 0);
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    check("backpressure_reads", 32'(rd_cnt), 32'd2);
    drain(0, 30);

    // Alternating ready
    load(12, 1'b1, 0);
    drain(1, 60);

    // Flush mid-burst with an in-flight word
    load(10, 1'b1, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check("flush_setup_inflight", 32'(infl_m), 32'd1);
    step(1'b0, 1'b1);
    check("post_flush_m_valid", 32'(m_valid), 32'd0);
    drain(0, 40);

    // Random ready with sporadic flushes
    load(40, 1'b1, 0);
    for (int i = 0; i < 150 && (fq.size() > 0 || expq.size() > 0); i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    drain(2, 100);

    // Reset mid-stream leaves FIFO contents alone
    load(6, 1'b1, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    do_reset();
    drain(0, 30);

`ifdef FIFO_DRAIN_STATS_EN
    // Counter wrap, flush keeps it, reset clears it
    do_reset();
    load(70000, 1'b0, 0);
    drain(0, 70100);
    check("pop_count_wrap", 32'(pop_count), 32'd4464);
    step(1'b0, 1'b1);
    check("pop_count_after_flush", 32'(pop_count), 32'd4464);
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
